// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, register-file write-port and scoreboard query signals of regfile_wb_arbiter.
// The master side drives requests and queries; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_waddr;
  logic [XLEN-1:0] alu_wdata;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            iss_mark;
  logic [AW-1:0]   iss_waddr;
  logic [AW-1:0]   chk_raddr1;
  logic [AW-1:0]   chk_raddr2;
  logic            busy1;
  logic            busy2;
  logic            idle;

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output mem_valid, mem_waddr, mem_wdata,
    output iss_mark, iss_waddr, chk_raddr1, chk_raddr2,
    input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy1, busy2, idle
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  mem_valid, mem_waddr, mem_wdata,
    input  iss_mark, iss_waddr, chk_raddr1, chk_raddr2,
    output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy1, busy2, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback,
// with a per-register pending scoreboard so issue can stall on RAW hazards.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave bus
);
  logic             last_grant;  // 1: load unit won the most recent transfer
  logic             grant_alu;
  logic             grant_mem;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [XLEN-1:0]  wr_data;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;

  // Ties go to whichever requester did not win last.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (bus.alu_valid && (!bus.mem_valid || last_grant)) begin
      grant_alu = 1'b1;
    end else if (bus.mem_valid) begin
      grant_mem = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      last_grant <= 1'b1;
    end else if (grant_alu) begin
      wr_en      <= (bus.alu_waddr != '0);
      wr_addr    <= bus.alu_waddr;
      wr_data    <= bus.alu_wdata;
      last_grant <= 1'b0;
    end else if (grant_mem) begin
      wr_en      <= (bus.mem_waddr != '0);
      wr_addr    <= bus.mem_waddr;
      wr_data    <= bus.mem_wdata;
      last_grant <= 1'b1;
    end else begin
      wr_en      <= 1'b0;
    end
  end

  // Clear on commit first, then set, so a newer producer of the same register stays pending.
  always_comb begin
    pending_next = pending;
    if (wr_en) begin
      pending_next[wr_addr] = 1'b0;
    end
    if (bus.iss_mark && (bus.iss_waddr != '0)) begin
      pending_next[bus.iss_waddr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  assign bus.rf_we     = wr_en;
  assign bus.rf_waddr  = wr_addr;
  assign bus.rf_wdata  = wr_data;
  assign bus.busy1     = pending[bus.chk_raddr1];
  assign bus.busy2     = pending[bus.chk_raddr2];
  assign bus.idle      = (pending == '0) && !wr_en;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration, write pipeline and scoreboard.
module tb_regfile_wb_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .NREGS(32), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who wins the next tie, what the write port shows, which regs are pending.
  bit              m_tie_alu;
  bit              m_we;
  logic [AW-1:0]   m_waddr;
  logic [XLEN-1:0] m_wdata;
  bit              m_pend [32];

  function automatic int exp_winner();  // 0 none, 1 ALU, 2 load
    if (bus.alu_valid && bus.mem_valid) return m_tie_alu ? 1 : 2;
    if (bus.alu_valid) return 1;
    if (bus.mem_valid) return 2;
    return 0;
  endfunction

  function automatic bit exp_idle();
    for (int r = 0; r < 32; r++) if (m_pend[r]) return 1'b0;
    return !m_we;
  endfunction

  task automatic model_clock();
    int w;
    w = exp_winner();
    if (reset) begin
      m_we = 0; m_waddr = '0; m_wdata = '0; m_tie_alu = 1;
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
      return;
    end
    if (m_we) m_pend[m_waddr] = 0;
    if (bus.iss_mark && bus.iss_waddr != 0) m_pend[bus.iss_waddr] = 1;
    if (w == 1) begin
      m_we = (bus.alu_waddr != 0); m_waddr = bus.alu_waddr; m_wdata = bus.alu_wdata; m_tie_alu = 0;
    end else if (w == 2) begin
      m_we = (bus.mem_waddr != 0); m_waddr = bus.mem_waddr; m_wdata = bus.mem_wdata; m_tie_alu = 1;
    end else begin
      m_we = 0;
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alu_valid = 0; bus.alu_waddr = '0; bus.alu_wdata = '0;
    bus.mem_valid = 0; bus.mem_waddr = '0; bus.mem_wdata = '0;
    bus.iss_mark = 0; bus.iss_waddr = '0; bus.chk_raddr1 = '0; bus.chk_raddr2 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b want=0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got=%0d want=0", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata got=%h want=0", bus.rf_wdata); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b want=1", bus.idle); end
    checks++; if ({bus.alu_ready, bus.mem_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b want=00", {bus.alu_ready, bus.mem_ready}); end
  endtask

  task automatic test_single_write();
    do_reset();
    bus.alu_valid = 1; bus.alu_waddr = 5'd5; bus.alu_wdata = 32'hDEADBEEF;
    #1;
    checks++; if ({bus.alu_ready, bus.mem_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got=%b want=10", {bus.alu_ready, bus.mem_ready}); end
    step();
    bus.alu_valid = 0;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_write got we=%b addr=%0d data=%h want we=1 addr=5 data=deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    step();
    checks++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd5) begin
      errors++; $display("FAIL single_after got we=%b addr=%0d want we=0 addr=5", bus.rf_we, bus.rf_waddr); end
  endtask

  task automatic test_contention();
    do_reset();
    bus.alu_valid = 1; bus.alu_waddr = 5'd3; bus.alu_wdata = 32'h11;
    bus.mem_valid = 1; bus.mem_waddr = 5'd4; bus.mem_wdata = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.alu_ready !== (i % 2 == 0) || bus.mem_ready !== (i % 2 == 1)) begin
        errors++; $display("FAIL contention_grant[%0d] got alu=%b mem=%b want alu=%b", i, bus.alu_ready, bus.mem_ready, (i % 2 == 0)); end
      step();
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== ((i % 2 == 0) ? 5'd3 : 5'd4) || bus.rf_wdata !== ((i % 2 == 0) ? 32'h11 : 32'h22)) begin
        errors++; $display("FAIL contention_write[%0d] got we=%b addr=%0d data=%h", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    end
    bus.alu_valid = 0; bus.mem_valid = 0;
    step();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL contention_drain got we=%b want 0", bus.rf_we); end
  endtask

  task automatic test_scoreboard();
    bus.iss_mark = 1; bus.iss_waddr = 5'd7; bus.chk_raddr1 = 5'd7;
    #1;
    checks++; if (bus.busy1 !== 1'b0) begin errors++; $display("FAIL sb_before_mark got=%b want=0", bus.busy1); end
    step();
    bus.iss_mark = 0;
    #1;
    checks++; if (bus.busy1 !== 1'b1 || bus.idle !== 1'b0) begin errors++; $display("FAIL sb_marked got busy1=%b idle=%b want 1 0", bus.busy1, bus.idle); end
    bus.mem_valid = 1; bus.mem_waddr = 5'd7; bus.mem_wdata = 32'h77;
    #1;
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL sb_mem_ready got=%b want=1", bus.mem_ready); end
    step();
    bus.mem_valid = 0;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.busy1 !== 1'b1) begin
      errors++; $display("FAIL sb_inflight got we=%b addr=%0d busy1=%b want 1 7 1", bus.rf_we, bus.rf_waddr, bus.busy1); end
    step();
    checks++; if (bus.busy1 !== 1'b0 || bus.idle !== 1'b1) begin errors++; $display("FAIL sb_cleared got busy1=%b idle=%b want 0 1", bus.busy1, bus.idle); end
  endtask

  task automatic test_collision();
    bus.iss_mark = 1; bus.iss_waddr = 5'd9;
    step();
    bus.iss_mark = 0;
    bus.alu_valid = 1; bus.alu_waddr = 5'd9; bus.alu_wdata = 32'h99;
    step();
    bus.alu_valid = 0;
    bus.iss_mark = 1; bus.iss_waddr = 5'd9; bus.chk_raddr2 = 5'd9;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9) begin errors++; $display("FAIL coll_setup got we=%b addr=%0d want 1 9", bus.rf_we, bus.rf_waddr); end
    step();
    bus.iss_mark = 0;
    checks++; if (bus.busy2 !== 1'b1 || bus.idle !== 1'b0) begin errors++; $display("FAIL coll_same got busy2=%b idle=%b want 1 0", bus.busy2, bus.idle); end
    bus.alu_valid = 1; bus.alu_waddr = 5'd9; bus.alu_wdata = 32'h9A;
    step();
    bus.alu_valid = 0;
    bus.iss_mark = 1; bus.iss_waddr = 5'd10; bus.chk_raddr1 = 5'd10;
    step();
    bus.iss_mark = 0;
    checks++; if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b0) begin errors++; $display("FAIL coll_diff got busy1=%b busy2=%b want 1 0", bus.busy1, bus.busy2); end
    bus.alu_valid = 1; bus.alu_waddr = 5'd10; bus.alu_wdata = 32'hA0;
    step();
    bus.alu_valid = 0;
    step();
    checks++; if (bus.busy1 !== 1'b0 || bus.idle !== 1'b1) begin errors++; $display("FAIL coll_drain got busy1=%b idle=%b want 0 1", bus.busy1, bus.idle); end
  endtask

  task automatic test_r0();
    bus.alu_valid = 1; bus.alu_waddr = 5'd0; bus.alu_wdata = 32'h5;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got=%b want=1", bus.alu_ready); end
    step();
    bus.alu_valid = 0;
    checks++; if (bus.rf_we !== 1'b0 || bus.idle !== 1'b1) begin errors++; $display("FAIL r0_write got we=%b idle=%b want 0 1", bus.rf_we, bus.idle); end
    bus.iss_mark = 1; bus.iss_waddr = 5'd0; bus.chk_raddr1 = 5'd0;
    step();
    bus.iss_mark = 0;
    checks++; if (bus.busy1 !== 1'b0 || bus.idle !== 1'b1) begin errors++; $display("FAIL r0_mark got busy1=%b idle=%b want 0 1", bus.busy1, bus.idle); end
  endtask

  task automatic test_reset_midstream();
    bus.iss_mark = 1; bus.iss_waddr = 5'd2;
    step();
    bus.iss_mark = 0;
    bus.alu_valid = 1; bus.alu_waddr = 5'd5; bus.alu_wdata = 32'hAB;
    step();
    bus.mem_valid = 1; bus.mem_waddr = 5'd6; bus.mem_wdata = 32'hCD;
    reset = 1;
    step();
    reset = 0;
    bus.alu_valid = 0; bus.mem_valid = 0;
    #1;
    checks++; if (bus.rf_we !== 1'b0 || bus.idle !== 1'b1) begin errors++; $display("FAIL midreset got we=%b idle=%b want 0 1", bus.rf_we, bus.idle); end
    for (int r = 0; r < 32; r++) begin
      bus.chk_raddr1 = AW'(r);
      #1;
      checks++; if (bus.busy1 !== 1'b0) begin errors++; $display("FAIL midreset_busy[%0d] got=%b want=0", r, bus.busy1); end
    end
    bus.alu_valid = 1; bus.mem_valid = 1;
    #1;
    checks++; if ({bus.alu_ready, bus.mem_ready} !== 2'b10) begin errors++; $display("FAIL midreset_tie got=%b want=10", {bus.alu_ready, bus.mem_ready}); end
    step();
    bus.alu_valid = 0; bus.mem_valid = 0;
    step();
  endtask

  task automatic test_random();
    int w;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!bus.alu_valid && $urandom_range(0, 2) != 0) begin
        bus.alu_valid = 1; bus.alu_waddr = AW'($urandom_range(0, 31)); bus.alu_wdata = XLEN'($urandom);
      end
      if (!bus.mem_valid && $urandom_range(0, 2) != 0) begin
        bus.mem_valid = 1; bus.mem_waddr = AW'($urandom_range(0, 31)); bus.mem_wdata = XLEN'($urandom);
      end
      bus.iss_mark   = ($urandom_range(0, 3) == 0);
      bus.iss_waddr  = AW'($urandom_range(0, 31));
      bus.chk_raddr1 = AW'($urandom_range(0, 31));
      bus.chk_raddr2 = AW'($urandom_range(0, 31));
      #1;
      w = exp_winner();
      checks++; if (bus.alu_ready !== (w == 1) || bus.mem_ready !== (w == 2)) begin
        errors++; $display("FAIL rnd_grant[%0d] got alu=%b mem=%b want winner=%0d", c, bus.alu_ready, bus.mem_ready, w); end
      checks++; if (bus.busy1 !== m_pend[bus.chk_raddr1] || bus.busy2 !== m_pend[bus.chk_raddr2] || bus.idle !== exp_idle()) begin
        errors++; $display("FAIL rnd_sb[%0d] got busy1=%b busy2=%b idle=%b want %b %b %b", c, bus.busy1, bus.busy2, bus.idle,
                           m_pend[bus.chk_raddr1], m_pend[bus.chk_raddr2], exp_idle()); end
      step();
      if (w == 1) bus.alu_valid = 0;
      if (w == 2) bus.mem_valid = 0;
      checks++; if (bus.rf_we !== m_we || (m_we && (bus.rf_waddr !== m_waddr || bus.rf_wdata !== m_wdata))) begin
        errors++; $display("FAIL rnd_write[%0d] got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h", c,
                           bus.rf_we, bus.rf_waddr, bus.rf_wdata, m_we, m_waddr, m_wdata); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1;
    clear_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_scoreboard();
    test_collision();
    test_r0();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
